// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants for the sequential binary-to-BCD converter.
//               Holds the BCD digit width, the FSM state encoding and the
//               helper that sizes the internal BCD field for a binary width.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Width of one packed BCD digit.
    localparam int BCD_W = 4;

    // State encoding.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

    // Number of BCD digits needed to hold any WIDTH-bit binary value:
    // each decimal digit covers a little more than 3 bits.
    function automatic int bcd_idigits(input int width);
        return (width + 2) / 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_convert_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_convert_seq_if
// Description : Data/handshake bundle between the divider, the converter and
//               the display multiplexer.
//               Res_in/Ready_in : binary result and ready flag from divider
//               Bcd/Overflow    : saturated packed BCD and overflow flag
//               Valid           : one-cycle update strobe
//               Busy            : conversion in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_convert_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]    Res_in;
    logic                Ready_in;
    logic [4*DIGITS-1:0] Bcd;
    logic                Overflow;
    logic                Valid;
    logic                Busy;

    // Upstream/downstream side (divider + display) drives the inputs.
    modport master (
        output Res_in, Ready_in,
        input  Bcd, Overflow, Valid, Busy
    );

    // Converter side.
    modport slave (
        input  Res_in, Ready_in,
        output Bcd, Overflow, Valid, Busy
    );
endinterface
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Combinational double-dabble correction cell: a BCD digit of
//               5 or more gets 3 added so the following left shift carries
//               correctly into the next decimal digit.
//               i_digit : digit before correction
//               o_digit : corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  wire  [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule
`default_nettype wire

// File: rtl/bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_convert_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3, one bit
//               per enabled clock). Captures the divider result on the rising
//               edge of Ready_in, converts it, and presents saturated packed
//               BCD with a one-cycle Valid strobe.
//               clk   : rising-edge clock
//               reset : asynchronous active-high reset
//               en    : clock enable (Ready edge detector always runs)
//               bus   : Res_in/Ready_in in, Bcd/Overflow/Valid/Busy out
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              en,
    bcd_convert_seq_if.slave bus
);
    localparam int IDIGITS = bcd_idigits(WIDTH);
    localparam int BCDF_W  = BCD_W * IDIGITS;
    localparam int SR_W    = BCDF_W + WIDTH;
    localparam logic [4:0] c_LAST = 5'(WIDTH - 1);

    // Registered state
    state_t              r_state;
    logic [SR_W-1:0]     r_sr;
    logic [4:0]          r_cnt;
    logic                r_ready_q;
    logic                r_pending;
    logic [WIDTH-1:0]    r_pend_val;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_ovf;
    logic                r_valid;
    logic                r_busy;

    // Next-state values
    state_t              w_state_n;
    logic [SR_W-1:0]     w_sr_n;
    logic [4:0]          w_cnt_n;
    logic                w_pending_n;
    logic [WIDTH-1:0]    w_pend_val_n;
    logic [4*DIGITS-1:0] w_bcd_n;
    logic                w_ovf_n;
    logic                w_valid_n;
    logic                w_busy_n;

    logic                w_start;
    logic [BCDF_W-1:0]   w_adj;
    logic [SR_W-1:0]     w_shifted;
    logic [BCDF_W-1:0]   w_field;
    logic [4*DIGITS-1:0] w_lo;
    logic                w_hi_nz;

    assign w_start = bus.Ready_in & ~r_ready_q;

    // Add-3 correction on every BCD digit of the current register.
    genvar gi;
    generate
        for (gi = 0; gi < IDIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_sr[WIDTH + BCD_W*gi +: BCD_W]),
                .o_digit (w_adj[BCD_W*gi +: BCD_W])
            );
        end
    endgenerate

    assign w_shifted = {w_adj[BCDF_W-2:0], r_sr[WIDTH-1:0], 1'b0};
    assign w_field   = w_shifted[SR_W-1:WIDTH];

    // Split the post-shift BCD field into presented digits and the
    // digits above them that signal saturation.
    generate
        if (IDIGITS > DIGITS) begin : g_wide
            assign w_lo    = w_field[4*DIGITS-1:0];
            assign w_hi_nz = |w_field[BCDF_W-1:4*DIGITS];
        end else begin : g_narrow
            assign w_lo    = (4*DIGITS)'(w_field);
            assign w_hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_n    = r_state;
        w_sr_n       = r_sr;
        w_cnt_n      = r_cnt;
        w_pending_n  = r_pending;
        w_pend_val_n = r_pend_val;
        w_bcd_n      = r_bcd;
        w_ovf_n      = r_ovf;
        w_valid_n    = 1'b0;
        w_busy_n     = r_busy;

        if (en) begin
            case (r_state)
                IDLE: begin
                    if (w_start || r_pending) begin
                        // A fresh edge is newer than anything left pending.
                        w_sr_n      = {{BCDF_W{1'b0}},
                                       (w_start ? bus.Res_in : r_pend_val)};
                        w_cnt_n     = 5'd0;
                        w_pending_n = 1'b0;
                        w_busy_n    = 1'b1;
                        w_state_n   = SHIFT;
                    end
                end
                SHIFT: begin
                    w_sr_n  = w_shifted;
                    w_cnt_n = r_cnt + 5'd1;
                    if (r_cnt == c_LAST) begin
                        w_bcd_n   = w_hi_nz ? {DIGITS{4'h9}} : w_lo;
                        w_ovf_n   = w_hi_nz;
                        w_valid_n = 1'b1;
                        w_busy_n  = 1'b0;
                        w_state_n = IDLE;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end

        // Requests that cannot be taken right now are queued one deep;
        // the newest value overwrites an older queued one.
        if (w_start && !(en && r_state == IDLE)) begin
            w_pending_n  = 1'b1;
            w_pend_val_n = bus.Res_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_cnt      <= 5'd0;
            r_ready_q  <= 1'b0;
            r_pending  <= 1'b0;
            r_pend_val <= '0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_sr       <= w_sr_n;
            r_cnt      <= w_cnt_n;
            r_ready_q  <= bus.Ready_in;
            r_pending  <= w_pending_n;
            r_pend_val <= w_pend_val_n;
            r_bcd      <= w_bcd_n;
            r_ovf      <= w_ovf_n;
            r_valid    <= w_valid_n;
            r_busy     <= w_busy_n;
        end
    end

    assign bus.Bcd      = r_bcd;
    assign bus.Overflow = r_ovf;
    assign bus.Valid    = r_valid;
    assign bus.Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_convert_seq
// Description : Directed self-checking bench for bcd_convert_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_seq;
    logic clk = 1'b0;
    logic reset;
    logic en;
    int   errors = 0;
    int   checks = 0;

    bcd_convert_seq_if #(.WIDTH(16), .DIGITS(4)) bus ();

    bcd_convert_seq #(.WIDTH(16), .DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Called just after a negedge with 'start_edges' posedges already seen
    // since (and including) the capture edge. Returns edge count at Valid.
    task automatic wait_valid(input int start_edges, output int edges,
                              output bit busy_ok);
        edges   = start_edges;
        busy_ok = 1'b1;
        while (!bus.Valid && edges < 200) begin
            if (!bus.Busy) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    // Called just after a negedge; pulses Ready for one capture edge and
    // returns positioned at the negedge after the capture edge.
    task automatic start_pulse(input logic [15:0] v);
        bus.Res_in   = v;
        bus.Ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.Ready_in = 1'b0;
    endtask

    task automatic do_conv(input logic [15:0] v, output int edges,
                           output bit busy_ok);
        start_pulse(v);
        wait_valid(1, edges, busy_ok);
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; bus.Ready_in = 1'b0; bus.Res_in = '0;
        #1;
        checks += 4;
        if (bus.Bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got=%h exp=0000", bus.Bcd); end
        if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.Overflow); end
        if (bus.Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.Valid); end
        if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int e; bit b;
        do_conv(16'd1234, e, b);
        checks += 5;
        if (e != 17) begin errors++; $display("FAIL basic_latency got=%0d exp=17", e); end
        if (bus.Bcd !== 16'h1234) begin errors++; $display("FAIL basic_bcd got=%h exp=1234", bus.Bcd); end
        if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", bus.Overflow); end
        if (!b) begin errors++; $display("FAIL basic_busy_during got=drop exp=high"); end
        if (bus.Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_valid got=%b exp=0", bus.Busy); end
        @(negedge clk);
        checks++;
        if (bus.Valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width got=%b exp=0", bus.Valid); end
    endtask

    task automatic test_table;
        logic [15:0] vin  [6] = '{16'd0, 16'd9999, 16'd65535, 16'd10000, 16'd42, 16'd7};
        logic [15:0] vbcd [6] = '{16'h0000, 16'h9999, 16'h9999, 16'h9999, 16'h0042, 16'h0007};
        logic        vovf [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int e; bit b;
        for (int i = 0; i < 6; i++) begin
            do_conv(vin[i], e, b);
            checks += 3;
            if (e != 17) begin errors++; $display("FAIL table_latency[%0d] got=%0d exp=17", i, e); end
            if (bus.Bcd !== vbcd[i]) begin errors++; $display("FAIL table_bcd[%0d] got=%h exp=%h", i, bus.Bcd, vbcd[i]); end
            if (bus.Overflow !== vovf[i]) begin errors++; $display("FAIL table_ovf[%0d] got=%b exp=%b", i, bus.Overflow, vovf[i]); end
        end
        repeat (5) @(negedge clk);
        checks += 2;
        if (bus.Bcd !== 16'h0007) begin errors++; $display("FAIL hold_bcd got=%h exp=0007", bus.Bcd); end
        if (bus.Valid !== 1'b0) begin errors++; $display("FAIL hold_valid got=%b exp=0", bus.Valid); end
    endtask

    task automatic test_ready_held;
        int nvalid = 0;
        bus.Res_in   = 16'd77;
        bus.Ready_in = 1'b1;
        repeat (5) @(negedge clk);
        bus.Ready_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Valid) nvalid++;
            @(negedge clk);
        end
        checks += 2;
        if (nvalid != 1) begin errors++; $display("FAIL held_valid_count got=%0d exp=1", nvalid); end
        if (bus.Bcd !== 16'h0077) begin errors++; $display("FAIL held_bcd got=%h exp=0077", bus.Bcd); end
    endtask

    task automatic test_back_to_back;
        int e; bit b;
        start_pulse(16'd500);
        repeat (4) @(negedge clk);
        bus.Res_in   = 16'd321;
        bus.Ready_in = 1'b1;
        @(negedge clk);
        bus.Ready_in = 1'b0;
        wait_valid(0, e, b);
        checks += 3;
        if (e >= 200) begin errors++; $display("FAIL b2b_first_timeout got=none exp=valid"); end
        if (bus.Bcd !== 16'h0500) begin errors++; $display("FAIL b2b_first_bcd got=%h exp=0500", bus.Bcd); end
        if (bus.Busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got=%b exp=0", bus.Busy); end
        @(negedge clk);
        checks += 2;
        if (bus.Busy !== 1'b1) begin errors++; $display("FAIL b2b_rebusy got=%b exp=1", bus.Busy); end
        if (bus.Valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got=%b exp=0", bus.Valid); end
        wait_valid(1, e, b);
        checks += 2;
        if (e != 17) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=17", e); end
        if (bus.Bcd !== 16'h0321) begin errors++; $display("FAIL b2b_second_bcd got=%h exp=0321", bus.Bcd); end
    endtask

    task automatic test_enable;
        int e; bit b;
        start_pulse(16'd808);
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b1) begin errors++; $display("FAIL en_busy_hold got=%b exp=1", bus.Busy); end
        en = 1'b1;
        wait_valid(9, e, b);
        checks += 3;
        if (e != 23) begin errors++; $display("FAIL en_latency got=%0d exp=23", e); end
        if (bus.Bcd !== 16'h0808) begin errors++; $display("FAIL en_bcd got=%h exp=0808", bus.Bcd); end
        if (!b) begin errors++; $display("FAIL en_busy_during got=drop exp=high"); end
    endtask

    task automatic test_reset_mid;
        int nvalid = 0;
        start_pulse(16'd1234);
        repeat (3) @(negedge clk);
        bus.Res_in   = 16'd99;
        bus.Ready_in = 1'b1;
        @(negedge clk);
        bus.Ready_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (bus.Bcd !== 16'h0000) begin errors++; $display("FAIL rmid_bcd got=%h exp=0000", bus.Bcd); end
        if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got=%b exp=0", bus.Overflow); end
        if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus.Busy); end
        if (bus.Valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.Valid); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Valid || bus.Busy) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin errors++; $display("FAIL rmid_no_activity got=%0d exp=0", nvalid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_ready_held();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
